// File: rtl/sparrow_encode.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, flags bad immediates/opcodes.
// Latency 1 cycle (accept at edge N, o_valid from N+1); throughput 1/cycle while i_ready=1.
// Backpressure: 2-entry (output + skid) buffer; o_ready = !skid_v, no combinational path from i_ready.

package sparrow_encode_pkg;
  typedef enum logic [6:0] {
    R_TYPE   = 7'b0110011,
    I_TYPE_0 = 7'b0010011,
    I_TYPE_1 = 7'b0000011,
    I_TYPE_2 = 7'b1100111,
    S_TYPE   = 7'b0100011,
    B_TYPE   = 7'b1100011,
    U_TYPE_0 = 7'b0110111,
    U_TYPE_1 = 7'b0010111,
    J_TYPE   = 7'b1101111
  } riscv_op_e;
endpackage

module sparrow_encode
  import sparrow_encode_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  riscv_op_e            i_op,
  input  logic [4:0]           i_rs1,
  input  logic [4:0]           i_rs2,
  input  logic [4:0]           i_rd,
  input  logic [2:0]           i_funct3,
  input  logic [6:0]           i_funct7,
  input  logic [31:0]          i_imm,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [31:0]          o_instr,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [6:0]  opc;
  logic [31:0] enc_instr;
  logic        enc_err;

  // Sign-extension checks: the dropped upper bits must all replicate the top kept bit.
  logic        imm_is_ok;   // I/S: 12-bit signed range
  logic        imm_b_ok;    // B: 13-bit signed range
  logic        imm_j_ok;    // J: 21-bit signed range

  logic        out_v;
  logic        skid_v;
  logic [31:0] skid_instr;
  logic        skid_err;
  logic        accept;
  logic        consume;

  assign opc       = i_op;
  assign imm_is_ok = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign imm_b_ok  = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign imm_j_ok  = (&i_imm[31:20]) | ~(|i_imm[31:20]);

  assign accept  = i_valid && o_ready;
  assign consume = out_v && i_ready;
  assign o_ready = !skid_v;
  assign o_valid = out_v;

  // Field packing per instruction format; any rejected request becomes a NOP.
  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b0;
    case (i_op)
      R_TYPE: begin
        enc_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, opc};
      end
      I_TYPE_0, I_TYPE_1, I_TYPE_2: begin
        enc_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, opc};
        enc_err   = !imm_is_ok;
      end
      S_TYPE: begin
        enc_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], opc};
        enc_err   = !imm_is_ok;
      end
      B_TYPE: begin
        enc_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                     i_imm[4:1], i_imm[11], opc};
        enc_err   = i_imm[0] || !imm_b_ok;
      end
      U_TYPE_0, U_TYPE_1: begin
        enc_instr = {i_imm[31:12], i_rd, opc};
        enc_err   = |i_imm[11:0];
      end
      J_TYPE: begin
        enc_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, opc};
        enc_err   = i_imm[0] || !imm_j_ok;
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
    if (enc_err) begin
      enc_instr = NOP;
    end
  end

  // Output register plus skid: new words go to the output when it frees up, otherwise park in skid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_v      <= 1'b0;
      skid_v     <= 1'b0;
      o_instr    <= 32'h0;
      o_err      <= 1'b0;
      skid_instr <= 32'h0;
      skid_err   <= 1'b0;
    end else if (consume) begin
      if (skid_v) begin
        // accept cannot coincide here since o_ready is low while skid_v
        o_instr <= skid_instr;
        o_err   <= skid_err;
        skid_v  <= 1'b0;
      end else if (accept) begin
        o_instr <= enc_instr;
        o_err   <= enc_err;
      end else begin
        out_v <= 1'b0;
      end
    end else if (accept) begin
      if (!out_v) begin
        o_instr <= enc_instr;
        o_err   <= enc_err;
        out_v   <= 1'b1;
      end else begin
        skid_instr <= enc_instr;
        skid_err   <= enc_err;
        skid_v     <= 1'b1;
      end
    end
  end

  // Saturating count of rejected requests, bumped at the accept edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err_cnt <= '0;
    end else if (accept && enc_err && (o_err_cnt != {ERR_CNT_W{1'b1}})) begin
      o_err_cnt <= o_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_sparrow_encode.sv
// Scoreboard bench for sparrow_encode: expected words are queued at accept, compared at output handshake.
// A second instance with ERR_CNT_W=2 shares the request bus to exercise counter saturation.
// Inputs change #1 after the rising edge; DUT is sampled on the falling edge or #1 after rising.

module tb_sparrow_encode;
  import sparrow_encode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  riscv_op_e   i_op;
  logic [4:0]  i_rs1, i_rs2, i_rd;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [31:0] i_imm;

  logic        o_ready, o_valid, o_err;
  logic [31:0] o_instr;
  logic [15:0] o_err_cnt;

  logic        o_ready_s, o_valid_s, o_err_s;
  logic [31:0] o_instr_s;
  logic [1:0]  o_err_cnt_s;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] sb_q[$];
  logic [32:0] cur_exp;
  logic [32:0] sb_e;

  always #5 clk = ~clk;

  sparrow_encode #(.ERR_CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr),
    .o_err(o_err), .o_err_cnt(o_err_cnt)
  );

  sparrow_encode #(.ERR_CNT_W(2)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready_s),
    .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .o_valid(o_valid_s), .i_ready(i_ready), .o_instr(o_instr_s),
    .o_err(o_err_s), .o_err_cnt(o_err_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard: compare the presented word first, then queue the request being accepted.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_word", o_instr, 32'hxxxx_xxxx);
        end else begin
          sb_e = sb_q.pop_front();
          check("sb_instr", o_instr, sb_e[31:0]);
          check("sb_err", {31'b0, o_err}, {31'b0, sb_e[32]});
        end
      end
      if (i_valid && o_ready) sb_q.push_back(cur_exp);
    end
  end

  task automatic drive(input riscv_op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic [31:0] exp_instr, input logic exp_err);
    i_op     = op;
    i_rd     = rd;
    i_rs1    = rs1;
    i_rs2    = rs2;
    i_funct3 = f3;
    i_funct7 = f7;
    i_imm    = imm;
    cur_exp  = {exp_err, exp_instr};
    i_valid  = 1'b1;
  endtask

  // Hold the request until accepted (bounded), return #1 after the accept edge.
  task automatic send(input riscv_op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] exp_instr, input logic exp_err);
    int n;
    drive(op, rd, rs1, rs2, f3, f7, imm, exp_instr, exp_err);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (o_ready) break;
    end
    if (n == 50) check("accept_timeout", {31'b0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0 && !o_valid) break;
    end
    check("drain_queue", sb_q.size(), 32'd0);
    check("drain_valid", {31'b0, o_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_op     = R_TYPE;
    i_rs1    = '0;
    i_rs2    = '0;
    i_rd     = '0;
    i_funct3 = '0;
    i_funct7 = '0;
    i_imm    = '0;
    cur_exp  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_err", {31'b0, o_err}, 32'd0);
    check("rst_err_cnt", {16'b0, o_err_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", {31'b0, o_ready}, 32'd1);

    // Single ADD, one-cycle latency
    send(R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
    check("add_valid", {31'b0, o_valid}, 32'd1);
    check("add_instr", o_instr, 32'h0020_81B3);
    check("add_err", {31'b0, o_err}, 32'd0);
    drain();

    // Back-to-back mix of formats
    send(I_TYPE_0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    check("b2b_addi", o_instr, 32'hFFF0_0093);
    send(B_TYPE,   5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    check("b2b_beq", o_instr, 32'hFE00_0EE3);
    send(J_TYPE,   5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0008, 32'h0080_00EF, 1'b0);
    check("b2b_jal", o_instr, 32'h0080_00EF);
    send(U_TYPE_0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    check("b2b_lui", o_instr, 32'h1234_52B7);
    drain();

    // Error cases and counter
    send(B_TYPE,   5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003, 32'h0000_0013, 1'b1);
    send(I_TYPE_0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0000_0013, 1'b1);
    check("err_instr", o_instr, 32'h0000_0013);
    check("err_flag", {31'b0, o_err}, 32'd1);
    check("err_cnt_2", {16'b0, o_err_cnt}, 32'd2);
    send(U_TYPE_0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001, 32'h0000_0013, 1'b1);
    check("err_cnt_3", {16'b0, o_err_cnt}, 32'd3);
    check("small_cnt_3", {30'b0, o_err_cnt_s}, 32'd3);
    drain();

    // Backpressure: two fill output+skid, third waits until the skid drains
    i_ready = 1'b0;
    send(R_TYPE,   5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h0020_81B3, 1'b0);
    send(I_TYPE_0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    fork
      send(U_TYPE_0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
      begin
        check("bp_ready_low", {31'b0, o_ready}, 32'd0);
        check("bp_valid", {31'b0, o_valid}, 32'd1);
        check("bp_instr", o_instr, 32'h0020_81B3);
        repeat (2) @(posedge clk);
        #1;
        check("bp_instr_stable", o_instr, 32'h0020_81B3);
        check("bp_ready_still_low", {31'b0, o_ready}, 32'd0);
        i_ready = 1'b1;
      end
    join
    check("bp_ready_back", {31'b0, o_ready}, 32'd1);
    drain();

    // Reset with both registers full drops in-flight words
    i_ready = 1'b0;
    send(R_TYPE,   5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h0020_81B3, 1'b0);
    send(U_TYPE_0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, o_valid}, 32'd0);
    check("mid_rst_err_cnt", {16'b0, o_err_cnt}, 32'd0);
    check("mid_rst_instr", o_instr, 32'h0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    send(J_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0008, 32'h0080_00EF, 1'b0);
    check("post_rst_valid", {31'b0, o_valid}, 32'd1);
    check("post_rst_instr", o_instr, 32'h0080_00EF);
    drain();

    // Boundary immediates and saturation of the 2-bit counter
    send(I_TYPE_0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    send(J_TYPE,   5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001, 32'h0000_0013, 1'b1);
    send(J_TYPE,   5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h0000_0013, 1'b1);
    send(riscv_op_e'(7'h7F), 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 32'h0000_0013, 1'b1);
    send(S_TYPE,   5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h0000_0008, 32'h0020_A423, 1'b0);
    send(U_TYPE_1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_5297, 1'b0);
    send(S_TYPE,   5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h0000_0800, 32'h0000_0013, 1'b1);
    check("sat_main_cnt", {16'b0, o_err_cnt}, 32'd4);
    check("sat_small_cnt", {30'b0, o_err_cnt_s}, 32'd3);
    check("small_instr", o_instr_s, 32'h0000_0013);
    check("small_err", {31'b0, o_err_s}, 32'd1);
    check("small_valid", {31'b0, o_valid_s}, 32'd1);
    check("small_ready", {31'b0, o_ready_s}, 32'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sparrow_encode.md
Name: sparrow_encode

Overview:
- Registered RISC-V RV32I instruction encoder: the inverse of the core decoder.
- Accepts decoded fields (opcode, rs1, rs2, rd, funct3, funct7, immediate) and packs them into a 32-bit instruction word.
- Validates immediate range and alignment, and counts rejected requests.
- Used by the debug/program loader and by testbenches to generate instruction streams for the fetch/decode path. Valid/ready on both sides, with a 2-entry skid so full throughput holds under backpressure.

Parameters:
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  request valid.
- o_ready  output  1  request accepted when i_valid && o_ready.
- i_op  input  riscv_op_e (7)  opcode.
- i_rs1  input  5  source register 1.
- i_rs2  input  5  source register 2.
- i_rd  input  5  destination register.
- i_funct3  input  3  funct3 field.
- i_funct7  input  7  funct7 field, used for R_TYPE only.
- i_imm  input  32  full-width immediate value.
- o_valid  output  1  encoded word valid.
- i_ready  input  1  downstream accepts when o_valid && i_ready.
- o_instr  output  32  encoded instruction.
- o_err  output  1  this beat's request was rejected.
- o_err_cnt  output  ERR_CNT_W  count of rejected requests, saturating.

Behaviour:
- Opcodes (riscv_op_e):
  - R_TYPE 0110011.
  - I_TYPE_0 0010011, I_TYPE_1 0000011, I_TYPE_2 1100111.
  - S_TYPE 0100011.
  - B_TYPE 1100011.
  - U_TYPE_0 0110111, U_TYPE_1 0010111.
  - J_TYPE 1101111.
- Common fields: rd→[11:7] (R/I/U/J), funct3→[14:12] (R/I/S/B), rs1→[19:15] (R/I/S/B), rs2→[24:20] (R/S/B), opcode→[6:0].
- R: funct7→[31:25].
- I: imm[11:0]→[31:20]. For shifts the caller supplies funct7 bits in imm[11:5].
- S: imm[11:5]→[31:25], imm[4:0]→[11:7].
- B: imm[12]→[31], imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→[7].
- U: imm[31:12]→[31:12].
- J: imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12].
- Error conditions (o_err=1, o_instr forced to 32'h0000_0013 NOP):
  - I/S: imm[31:11] not all equal.
  - B: imm[0]≠0, or imm[31:12] not all equal.
  - J: imm[0]≠0, or imm[31:20] not all equal.
  - U: imm[11:0]≠0.
  - Opcode not in list.
  - R ignores i_imm; R never errors on immediate.
- Pipeline:
  - Output register (out_v) plus skid register (skid_v).
  - o_valid = out_v. o_ready = !skid_v (registered, no combinational path from i_ready).
  - Latency: accepted at edge N → o_valid at cycle N+1. Throughput 1/cycle while i_ready=1.
  - On accept: if !out_v or output consumed this cycle (and skid empty) → load output reg; else → load skid.
  - On output consume with skid_v → skid moves to output reg, skid_v cleared.
  - Simultaneous accept + consume with skid_v: not possible, because o_ready=0 when skid_v.
  - Order is strictly preserved. o_instr/o_err held stable while o_valid && !i_ready.
- o_err_cnt: increments by 1 on each accepted request that errors, at the accept edge. Saturates at all-ones.
- Reset (async, any time, including mid-transfer): out_v=0, skid_v=0, o_valid=0, o_ready=1 after release, o_instr=0, o_err=0, o_err_cnt=0. In-flight words are dropped.

Test Plan:
- ADD x3,x1,x2 (R_TYPE, f3=0, f7=0), i_ready=1 → one cycle later o_valid=1, o_instr=0x002081B3, o_err=0.
- Back-to-back ADDI x1,x0,-1 (imm=0xFFFFFFFF); BEQ x0,x0,-4; JAL x1,8; LUI x5,0x12345000 → 0xFFF00093, 0xFE000EE3, 0x008000EF, 0x123452B7 on consecutive cycles.
- B_TYPE imm=3; then I_TYPE_0 imm=0x800 → both o_err=1 with o_instr=0x00000013, o_err_cnt=2. U_TYPE_0 imm=0x1 → o_err_cnt=3.
- Backpressure: i_ready=0 with 3 requests offered → two accepted, o_ready=0 from the following cycle, o_instr stable. Raise i_ready → words emerge in order, o_ready returns to 1.
- Assert i_rst with both registers full → o_valid=0 immediately, o_err_cnt=0. After release the first new request's encoding appears, with no stale word.
- Force o_err_cnt to all-ones (ERR_CNT_W=2, 4 errors) → counter stays 3.
